// File: rtl/fetch_sched.sv
// Instruction fetch sequencer with RAW-hazard bubble insertion.
// Owns the PC, registers the fetched word into IF/ID, tracks recently
// issued destination registers in a small shift scoreboard, and handles
// branch redirect/squash, downstream stall and end-of-program halt.
//
// state  | meaning
// S_RUN  | fetching: issue ins_in or insert a bubble on a RAW hazard
// S_HALT | PC at or past ROM_DEPTH; only NOPs until branch or reset
module fetch_sched #(
   parameter int unsigned ROM_DEPTH = 82,
   parameter int          HAZ_DEPTH = 3,
   parameter logic [31:0] NOP       = 32'h00000000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] pc_out,
   input  logic [31:0] ins_in,
   input  logic [4:0]  rs1_in,
   input  logic [4:0]  rs2_in,
   input  logic [1:0]  rs_use,
   input  logic [4:0]  rd_in,
   input  logic        rd_wr,
   input  logic        stall_in,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   output logic [31:0] if_ins,
   output logic [31:0] if_pc,
   output logic        if_valid,
   output logic        halted,
   output logic [15:0] bubble_cnt
);

   typedef enum logic {S_RUN, S_HALT} state_t;

   state_t                      state_q, state_d;
   logic [31:0]                 pc_q, pc_d;
   logic [31:0]                 if_ins_q, if_ins_d;
   logic [31:0]                 if_pc_q, if_pc_d;
   logic                        if_valid_q, if_valid_d;
   logic [15:0]                 bubble_q, bubble_d;
   logic [HAZ_DEPTH-1:0]        sb_v_q, sb_v_d;
   logic [HAZ_DEPTH-1:0][4:0]   sb_rd_q, sb_rd_d;
   logic                        hazard;
   logic [31:0]                 pc_plus1;

   assign pc_plus1 = pc_q + 32'd1;

   // RAW check of the word at pc_out against every valid scoreboard entry
   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < HAZ_DEPTH; i++) begin
         if (sb_v_q[i] && rs_use[0] && (rs1_in != 5'd0) && (sb_rd_q[i] == rs1_in))
            hazard = 1'b1;
         if (sb_v_q[i] && rs_use[1] && (rs2_in != 5'd0) && (sb_rd_q[i] == rs2_in))
            hazard = 1'b1;
      end
   end

   // Next-state and IF/ID update, priority br_taken > stall > HALT > hazard > issue
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      if_ins_d   = if_ins_q;
      if_pc_d    = if_pc_q;
      if_valid_d = if_valid_q;
      bubble_d   = bubble_q;
      sb_v_d     = sb_v_q;
      sb_rd_d    = sb_rd_q;

      if (br_taken) begin
         pc_d       = br_target;
         if_ins_d   = NOP;
         if_pc_d    = br_target;
         if_valid_d = 1'b0;
         // the word sitting in ID is squashed, so it must not block reads
         // as it ages; nothing new enters at the head
         for (int i = 1; i < HAZ_DEPTH; i++) begin
            sb_v_d[i]  = (i == 1) ? 1'b0 : sb_v_q[i-1];
            sb_rd_d[i] = sb_rd_q[i-1];
         end
         sb_v_d[0]  = 1'b0;
         sb_rd_d[0] = 5'd0;
         state_d    = (br_target >= ROM_DEPTH) ? S_HALT : S_RUN;
      end else if (!stall_in) begin
         for (int i = 1; i < HAZ_DEPTH; i++) begin
            sb_v_d[i]  = sb_v_q[i-1];
            sb_rd_d[i] = sb_rd_q[i-1];
         end
         sb_v_d[0]  = 1'b0;
         sb_rd_d[0] = 5'd0;
         if (state_q == S_HALT || hazard) begin
            if_ins_d   = NOP;
            if_valid_d = 1'b0;
            if (state_q == S_RUN && bubble_q != 16'hFFFF)
               bubble_d = bubble_q + 16'd1;
         end else begin
            if_ins_d   = ins_in;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            pc_d       = pc_plus1;
            sb_v_d[0]  = rd_wr && (rd_in != 5'd0);
            sb_rd_d[0] = rd_in;
            if (pc_plus1 >= ROM_DEPTH)
               state_d = S_HALT;
         end
      end
   end

   // State, PC, IF/ID and scoreboard registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_RUN;
         pc_q       <= 32'd0;
         if_ins_q   <= NOP;
         if_pc_q    <= 32'd0;
         if_valid_q <= 1'b0;
         bubble_q   <= 16'd0;
         sb_v_q     <= '0;
         sb_rd_q    <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         if_ins_q   <= if_ins_d;
         if_pc_q    <= if_pc_d;
         if_valid_q <= if_valid_d;
         bubble_q   <= bubble_d;
         sb_v_q     <= sb_v_d;
         sb_rd_q    <= sb_rd_d;
      end
   end

   assign pc_out     = pc_q;
   assign if_ins     = if_ins_q;
   assign if_pc      = if_pc_q;
   assign if_valid   = if_valid_q;
   assign halted     = (state_q == S_HALT);
   assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_fetch_sched.sv
// Bench for fetch_sched: directed scenarios then random traffic, all
// compared each cycle against a queue-based reference model.
module tb_fetch_sched;

   localparam int ROM_DEPTH = 82;
   localparam int HAZ_DEPTH = 3;

   logic        clk = 1'b0;
   logic        rst, stall_in, br_taken, rd_wr;
   logic [31:0] br_target, pc_out, ins_in, if_ins, if_pc;
   logic [4:0]  rs1_in, rs2_in, rd_in;
   logic [1:0]  rs_use;
   logic        if_valid, halted;
   logic [15:0] bubble_cnt;

   logic [31:0] rom [0:127];

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic [31:0] m_pc, m_ins, m_ifpc;
   logic        m_valid, m_halt;
   int          m_bub;
   int          m_sb[$];   // newest first; 0 means no blocking register

   always #5 clk = ~clk;

   assign ins_in = (pc_out < ROM_DEPTH) ? rom[pc_out[6:0]] : 32'h0;
   assign rs1_in = ins_in[19:15];
   assign rs2_in = ins_in[24:20];
   assign rd_in  = ins_in[11:7];
   assign rd_wr  = ins_in[2];
   assign rs_use = ins_in[1:0];

   fetch_sched #(.ROM_DEPTH(ROM_DEPTH), .HAZ_DEPTH(HAZ_DEPTH), .NOP(32'h0)) dut (
      .clk(clk), .rst(rst), .pc_out(pc_out), .ins_in(ins_in),
      .rs1_in(rs1_in), .rs2_in(rs2_in), .rs_use(rs_use), .rd_in(rd_in),
      .rd_wr(rd_wr), .stall_in(stall_in), .br_taken(br_taken),
      .br_target(br_target), .if_ins(if_ins), .if_pc(if_pc),
      .if_valid(if_valid), .halted(halted), .bubble_cnt(bubble_cnt)
   );

   function automatic logic [31:0] mk(int rs1, int rs2, int rd, int wr, int use_);
      return (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(rd) << 7) |
             (32'(wr) << 2) | 32'(use_);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic sb_push(input int v);
      m_sb.push_front(v);
      void'(m_sb.pop_back());
   endtask

   task automatic model_step(input bit r, input bit s, input bit b, input logic [31:0] t);
      logic [31:0] w;
      int rs1, rs2, rd;
      bit haz;
      if (r) begin
         m_pc = 0; m_ins = 0; m_ifpc = 0; m_valid = 0; m_halt = 0; m_bub = 0;
         m_sb = {};
         for (int i = 0; i < HAZ_DEPTH; i++) m_sb.push_back(0);
      end else if (b) begin
         m_pc = t; m_ins = 0; m_ifpc = t; m_valid = 0;
         m_sb[0] = 0;
         sb_push(0);
         m_halt = (t >= ROM_DEPTH);
      end else if (s) begin
         // everything holds
      end else if (m_halt) begin
         m_ins = 0; m_valid = 0;
         sb_push(0);
      end else begin
         w = (m_pc < ROM_DEPTH) ? rom[m_pc[6:0]] : 32'h0;
         rs1 = int'(w[19:15]); rs2 = int'(w[24:20]); rd = int'(w[11:7]);
         haz = 0;
         foreach (m_sb[i]) begin
            if (m_sb[i] != 0 && w[0] && rs1 == m_sb[i]) haz = 1;
            if (m_sb[i] != 0 && w[1] && rs2 == m_sb[i]) haz = 1;
         end
         if (haz) begin
            m_ins = 0; m_valid = 0;
            sb_push(0);
            if (m_bub < 65535) m_bub++;
         end else begin
            m_ins = w; m_ifpc = m_pc; m_valid = 1;
            sb_push(w[2] ? rd : 0);
            m_pc = m_pc + 1;
            m_halt = (m_pc >= ROM_DEPTH);
         end
      end
   endtask

   // one clock: drive inputs, advance model, sample #1 after the edge, compare
   task automatic cycle(input bit r, input bit s, input bit b, input logic [31:0] t);
      rst = r; stall_in = s; br_taken = b; br_target = t;
      model_step(r, s, b, t);
      @(posedge clk);
      #1;
      chk("pc_out", pc_out, m_pc);
      chk("if_ins", if_ins, m_ins);
      chk("if_pc", if_pc, m_ifpc);
      chk("if_valid", 32'(if_valid), 32'(m_valid));
      chk("halted", 32'(halted), 32'(m_halt));
      chk("bubble_cnt", 32'(bubble_cnt), 32'(m_bub));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
   endtask

   task automatic rom_clear();
      for (int i = 0; i < 128; i++) rom[i] = 32'h0;
   endtask

   initial begin
      rst = 1; stall_in = 0; br_taken = 0; br_target = 0;
      rom_clear();

      // straight-line independent code
      cycle(1, 0, 0, 0);
      chk("reset_pc", pc_out, 32'd0);
      chk("reset_valid", 32'(if_valid), 32'd0);
      run(5);
      chk("seq_pc", pc_out, 32'd5);
      chk("seq_ifpc", if_pc, 32'd4);
      chk("seq_bub", 32'(bubble_cnt), 32'd0);

      // RAW on rs1: three bubbles with pc held at 1
      rom[0] = mk(0, 0, 1, 1, 0);
      rom[1] = mk(1, 0, 2, 1, 1);
      cycle(1, 0, 0, 0);
      run(4);
      chk("haz_pc_held", pc_out, 32'd1);
      chk("haz_bub", 32'(bubble_cnt), 32'd3);
      run(1);
      chk("haz_issue_pc", pc_out, 32'd2);
      chk("haz_issue_ifpc", if_pc, 32'd1);

      // rd 0 never blocks
      rom[0] = mk(0, 0, 0, 1, 0);
      rom[1] = mk(0, 0, 3, 1, 1);
      cycle(1, 0, 0, 0);
      run(2);
      chk("rd0_pc", pc_out, 32'd2);
      chk("rd0_bub", 32'(bubble_cnt), 32'd0);

      // branch beats stall while a hazard is pending
      rom[0] = mk(0, 0, 1, 1, 0);
      rom[1] = mk(1, 0, 2, 1, 1);
      cycle(1, 0, 0, 0);
      run(2);
      cycle(0, 1, 1, 20);
      chk("br_pc", pc_out, 32'd20);
      chk("br_valid", 32'(if_valid), 32'd0);
      chk("br_bub", 32'(bubble_cnt), 32'd1);
      run(3);

      // stall holds for two cycles then resumes
      cycle(0, 1, 0, 0);
      cycle(0, 1, 0, 0);
      chk("stall_pc", pc_out, 32'd23);
      run(2);

      // run off the end of the ROM, then branch back in
      rom_clear();
      cycle(1, 0, 0, 0);
      run(ROM_DEPTH);
      chk("end_pc", pc_out, 32'd82);
      chk("end_halted", 32'(halted), 32'd1);
      run(3);
      chk("halt_hold_pc", pc_out, 32'd82);
      cycle(0, 0, 1, 5);
      chk("resume_halted", 32'(halted), 32'd0);
      run(1);
      chk("resume_ifpc", if_pc, 32'd5);

      // reset in the middle of a hazard
      rom[0] = mk(0, 0, 1, 1, 0);
      rom[1] = mk(1, 0, 2, 1, 1);
      cycle(1, 0, 0, 0);
      run(2);
      cycle(1, 0, 0, 0);
      chk("rst_haz_pc", pc_out, 32'd0);
      chk("rst_haz_bub", 32'(bubble_cnt), 32'd0);

      // random programs and control traffic against the model
      for (int i = 0; i < ROM_DEPTH; i++)
         rom[i] = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 1), $urandom_range(0, 3));
      cycle(1, 0, 0, 0);
      for (int i = 0; i < 1500; i++) begin
         int p;
         p = $urandom_range(0, 99);
         if (p == 0)       cycle(1, 0, 0, 0);
         else if (p < 5)   cycle(0, $urandom_range(0, 1), 1, $urandom_range(0, 90));
         else if (p < 15)  cycle(0, 1, 0, 0);
         else              cycle(0, 0, 0, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
